// File: rtl/median_window_gen_if.sv
// Pixel-stream / 3x3 window bundle for median_window_gen.
//   in_valid, in_sof, in_data : raster-order pixel input, no backpressure
//   out_valid                 : a0..c2 hold a complete window this cycle
//   a0..c2                    : window rows 0..2 (lines y-2..y), columns a/b/c = x-2, x-1, x
interface median_window_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_sof;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] a0, b0, c0;
  logic [DATA_WIDTH-1:0] a1, b1, c1;
  logic [DATA_WIDTH-1:0] a2, b2, c2;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, a0, b0, c0, a1, b1, c1, a2, b2, c2
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, a0, b0, c0, a1, b1, c1, a2, b2, c2
  );
endinterface

// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator for a 3x3 median sorting network.
// Buffers the two previous lines and presents every fully-inside 3x3
// neighbourhood, registered, one clock after its bottom-right pixel.
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   win_if : slave side of median_window_gen_if (pixel in, window out)
module median_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WIDTH = 640,
  parameter int X_WIDTH    = 10
) (
  input  logic           clk,
  input  logic           rst,
  median_window_gen_if.slave win_if
);
  localparam int AW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(LINE_WIDTH - 1);

  typedef logic [2:0][DATA_WIDTH-1:0] col_t; // [0]=line y-2, [1]=y-1, [2]=y

  logic [DATA_WIDTH-1:0] lb_top [LINE_WIDTH];
  logic [DATA_WIDTH-1:0] lb_mid [LINE_WIDTH];

  logic [X_WIDTH-1:0]    x_q, x_d, x_eff;
  logic [1:0]            y_q, y_d, y_eff;
  col_t                  col_a_q, col_b_q, col_c_q;
  col_t                  col_a_d, col_b_d, col_c_d;
  logic                  vld_q, vld_d;
  logic [AW-1:0]         idx;
  logic [DATA_WIDTH-1:0] top_rd, mid_rd;

  // A start-of-frame pixel is placed at (0,0) before anything uses x/y.
  assign x_eff  = win_if.in_sof ? '0 : x_q;
  assign y_eff  = win_if.in_sof ? '0 : y_q;
  assign idx    = x_eff[AW-1:0];
  assign top_rd = lb_top[idx];
  assign mid_rd = lb_mid[idx];

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    col_a_d = col_a_q;
    col_b_d = col_b_q;
    col_c_d = col_c_q;
    vld_d   = 1'b0;
    if (win_if.in_valid) begin
      col_a_d = col_b_q;
      col_b_d = col_c_q;
      col_c_d = {win_if.in_data, mid_rd, top_rd};
      // Columns 0/1 still shift stale data through but never qualify.
      vld_d   = (x_eff >= X_WIDTH'(2)) && (y_eff == 2'd2);
      if (x_eff == X_LAST) begin
        x_d = '0;
        y_d = (y_eff == 2'd2) ? 2'd2 : y_eff + 2'd1;
      end else begin
        x_d = x_eff + X_WIDTH'(1);
        y_d = y_eff;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      col_a_q <= '0;
      col_b_q <= '0;
      col_c_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      col_a_q <= col_a_d;
      col_b_q <= col_b_d;
      col_c_q <= col_c_d;
      vld_q   <= vld_d;
    end
  end

  // Line buffers need no reset: rows are rewritten before reaching a valid window.
  // Reads above are combinational, so the same-column read sees the old value.
  always_ff @(posedge clk) begin
    if (win_if.in_valid) begin
      lb_top[idx] <= mid_rd;
      lb_mid[idx] <= win_if.in_data;
    end
  end

  assign win_if.out_valid = vld_q;
  assign win_if.a0 = col_a_q[0];
  assign win_if.b0 = col_b_q[0];
  assign win_if.c0 = col_c_q[0];
  assign win_if.a1 = col_a_q[1];
  assign win_if.b1 = col_b_q[1];
  assign win_if.c1 = col_c_q[1];
  assign win_if.a2 = col_a_q[2];
  assign win_if.b2 = col_b_q[2];
  assign win_if.c2 = col_c_q[2];
endmodule

// File: tb/tb_median_window_gen.sv
module tb_median_window_gen;
  localparam int LW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  median_window_gen_if #(.DATA_WIDTH(DW)) bus ();

  median_window_gen #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .X_WIDTH(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .win_if (bus)
  );

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int ffmed = 0;

  // Reference: whole image kept per line (mod 64), tracked by absolute (x,y).
  logic [7:0]  img [64][LW];
  int          mx = 0, my = 0;
  bit          exp_v = 1'b0;
  logic [71:0] exp_w = '0;

  logic [71:0] win_act;
  assign win_act = {bus.a0, bus.b0, bus.c0, bus.a1, bus.b1, bus.c1, bus.a2, bus.b2, bus.c2};

  localparam logic [71:0] WIN_A = 72'h000102_101112_202122;
  localparam logic [71:0] WIN_B = 72'h010203_111213_212223;

  function automatic logic [7:0] med9(input logic [71:0] w);
    logic [7:0] v [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) v[i] = w[71-8*i -: 8];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
    return v[4];
  endfunction

  function automatic logic [7:0] pix(input int i);
    return 8'(16 * (i / LW) + (i % LW));
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  // Drive one cycle at the falling edge and advance the reference model.
  task automatic cyc(input bit v, input bit sof, input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_data  = d;
    if (v) begin
      if (sof) begin mx = 0; my = 0; end
      img[my % 64][mx] = d;
      exp_v = (mx >= 2) && (my >= 2);
      if (exp_v)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            exp_w[71-8*(r*3+c) -: 8] = img[(my - 2 + r) % 64][mx - 2 + c];
      mx++;
      if (mx == LW) begin mx = 0; my++; end
    end else begin
      exp_v = 1'b0;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 72'(bus.out_valid), 72'd0);
    chk("rst_async_win", win_act, 72'd0);
    mx = 0; my = 0; exp_v = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle-by-cycle compare against the reference model.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      checks++;
      if (bus.out_valid !== exp_v) begin
        failures++;
        $display("FAIL out_valid t=%0t actual=%b expected=%b", $time, bus.out_valid, exp_v);
      end
      if (exp_v) begin
        checks++;
        if (win_act !== exp_w) begin
          failures++;
          $display("FAIL window t=%0t actual=%h expected=%h", $time, win_act, exp_w);
        end
      end
      if (bus.out_valid === 1'b1) begin
        pulses++;
        if (med9(win_act) == 8'hFF) ffmed++;
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = '0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < LW; c++) img[r][c] = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 72'(bus.out_valid), 72'd0);
    chk("reset_win", win_act, 72'd0);
    rst = 1'b0;

    // Continuous frame with literal window pins and wrap checks.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, i == 0, pix(i));
      if (i == 10) begin
        settle();
        chk("s1_first_valid", 72'(bus.out_valid), 72'd1);
        chk("s1_first_win", win_act, WIN_A);
        chk("s1_first_median", 72'(med9(win_act)), 72'h11);
      end
      if (i == 11) begin settle(); chk("s1_second_win", win_act, WIN_B); end
      if (i == 12 || i == 13) begin settle(); chk("s1_wrap_valid", 72'(bus.out_valid), 72'd0); end
    end
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    chk("s1_pulses", 72'(pulses), 72'd4);

    // Same frame with a gap after every pixel.
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, i == 0, pix(i));
      if (i == 10) begin settle(); chk("s2_first_win", win_act, WIN_A); end
      cyc(1'b0, 1'b0, 8'hAA);
    end
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    chk("s2_pulses", 72'(pulses), 72'd4);

    // Restart the frame with in_sof partway through line 1.
    for (int i = 0; i < 6; i++) cyc(1'b1, i == 0, pix(i));
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, i == 0, pix(i));
      if (i == 9)  begin settle(); chk("s3_no_early_valid", 72'(pulses), 72'd0); end
      if (i == 10) begin settle(); chk("s3_first_win", win_act, WIN_A); end
    end
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    chk("s3_pulses", 72'(pulses), 72'd4);

    // Reset mid-line 3, then a frame without in_sof.
    for (int i = 0; i < 14; i++) cyc(1'b1, i == 0, pix(i));
    do_reset();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'b0, pix(i));
      if (i == 10) begin settle(); chk("s4_first_win", win_act, WIN_A); end
    end
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    chk("s4_pulses", 72'(pulses), 72'd4);

    // Impulse rejection: single 0x00 in an all-0xFF frame.
    pulses = 0;
    ffmed  = 0;
    for (int i = 0; i < 16; i++) cyc(1'b1, i == 0, (i == 5) ? 8'h00 : 8'hFF);
    repeat (2) cyc(1'b0, 1'b0, 8'h00);
    chk("s5_pulses", 72'(pulses), 72'd4);
    chk("s5_median_ff", 72'(ffmed), 72'd4);

    // Randomized traffic with gaps, occasional restarts and resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      else cyc($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, 8'($urandom));
    end
    repeat (2) cyc(1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/median_window_gen.md
# median_window_gen

Streaming 3x3 window generator that feeds the 3x3 median sorting network. It accepts a raster-order pixel stream, buffers the two previous lines internally, and presents the nine pixels of each fully-inside 3x3 neighbourhood on a0..c2 with a qualifying out_valid. The median network is purely combinational and hangs directly off these outputs, so the filtered pixel is valid in the same cycle as out_valid.

## Interface
- DATA_WIDTH, 8, pixel width in bits
- LINE_WIDTH, 640, pixels per image line (must be >= 3)
- X_WIDTH, 10, column counter width (must satisfy 2^X_WIDTH >= LINE_WIDTH)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_data/in_sof qualify this cycle; no backpressure
- in_sof  in  1  first pixel of a frame, sampled only with in_valid
- in_data  in  DATA_WIDTH  input pixel, raster order
- out_valid  out  1  a0..c2 hold a complete window this cycle
- a0, b0, c0  out  DATA_WIDTH  row 0 = line y-2, columns x-2, x-1, x
- a1, b1, c1  out  DATA_WIDTH  row 1 = line y-1, columns x-2, x-1, x
- a2, b2, c2  out  DATA_WIDTH  row 2 = line y, columns x-2, x-1, x

## Operation
- Two line buffers, each LINE_WIDTH x DATA_WIDTH: lb_top holds line y-2, lb_mid holds line y-1, both indexed by column x.
- Column counter x (X_WIDTH bits) and row counter y (2-bit, saturating at 2).
- On an accepted pixel (in_valid=1) at column x:
  - read lb_top[x] and lb_mid[x] (old contents), then write lb_top[x] <= lb_mid[x] and lb_mid[x] <= in_data;
  - shift the window: column a <= column b, column b <= column c, column c <= {lb_top[x], lb_mid[x], in_data} for rows 0, 1, 2;
  - out_valid <= (x >= 2) && (y == 2);
  - x == LINE_WIDTH-1: x <= 0 and y <= min(y+1, 2); otherwise x <= x+1.
- in_sof with in_valid: that pixel is treated as (x=0, y=0); counters are forced before use, so it is written at column 0 and the next x is 1. Line-buffer contents are not cleared; they are overwritten before they can reach a valid window.
- in_valid=0: counters, line buffers and window registers hold; out_valid <= 0.
- No border padding: windows are emitted only for centres (1..LINE_WIDTH-2, 1..H-2), giving LINE_WIDTH-2 windows per line from line 2 onward.
- Windows never straddle lines. At x = 0 and x = 1 out_valid is 0 even though stale columns are shifted through.

## Timing
- Latency: one clock from the accepted pixel at (x, y) to out_valid and the window whose bottom-right pixel is (x, y).
- Window outputs are registered and hold their last value while out_valid=0.
- Line-buffer read returns the pre-write value when reading and writing the same column in the same cycle (read-before-write). Registers or an inferred RAM are both acceptable, provided the 1-cycle latency holds.
- Reset (asynchronous, at any time, including mid-line):
  - out_valid=0, all window outputs 0, x=0, y=0;
  - line-buffer contents are don't-care;
  - the first pixel after reset is treated as (0,0) whether or not in_sof is asserted.
- Throughput: one pixel per clock sustained. Arbitrary in_valid gaps are allowed, including within a line.

## Test plan
Benches use LINE_WIDTH=4, pixel value = 16*y + x.
- Continuous frame of 4 lines (16 pixels) -> out_valid first high one clock after pixel index 10 (x=2, y=2). Window is a0..c0 = 00,01,02; a1..c1 = 10,11,12; a2..c2 = 20,21,22, and the median output is 0x11. Next cycle the window is 01,02,03 / 11,12,13 / 21,22,23. out_valid pulses total 4 for the frame.
- Same frame with in_valid toggling 1,0,1,0 -> identical window sequence, each valid exactly one clock after its completing pixel, and out_valid is never high in gap cycles.
- in_sof asserted on pixel index 6 of a running frame -> that pixel is (0,0) and no out_valid occurs until 10 more pixels have been accepted. The first window after the restart contains only post-sof pixels.
- rst pulsed mid-line 3 (asynchronously, between edges) -> out_valid and all outputs go to 0 immediately. The subsequent 16-pixel frame without in_sof produces exactly the same 4 windows as the first scenario.
- All-0xFF frame with a single 0x00 at (x=1, y=1) -> the 4 windows have median 0xFF, confirming that an impulse is rejected. The frame is 4 lines, so the windows cover rows 0-2 and 1-3.
- Line wrap check: pixels at x=0 and x=1 of lines 3 and later -> out_valid=0 on the cycles following them.
